// File: rtl/hrange_sched.sv
// hrange_sched -- round-robin scheduler sharing one hrange-style generator
// among N_REQ requesters.
//
// A job (base, limit, step) is accepted from the winning requester while idle.
// The arguments are latched onto gen_base/limit/step and gen_start is pulsed.
// The generator's valid/ready stream is then steered to that requester, and
// the generator is released once its done beat has been taken.
//
// Ports:
//   _clock, _reset_n          clock, async active-low reset (also resets generator)
//   req_start[N_REQ]          level request per requester, held until granted
//   req_base/limit/step       packed per-requester arguments (slice i for requester i)
//   req_ready[N_REQ]          per-requester consumer ready
//   req_grant[N_REQ]          one-hot one-cycle pulse when a job launches
//   out_valid[N_REQ]          per-requester valid (owner bit only)
//   out_0, out_1              shared data, generator outputs while running, else 0
//   out_done[N_REQ]           one-cycle completion pulse to the owner
//   busy                      high whenever not idle
//   owner                     current or last owner index
//   jobs_done                 saturating completed-job counter
//   gen_start, gen_base/limit/step, gen_ready   drive the generator
//   gen_valid, gen_done, gen_0, gen_1           generator status and data
module hrange_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int OWW   = $clog2(N_REQ)
) (
  input  logic                      _clock,
  input  logic                      _reset_n,
  input  logic [N_REQ-1:0]          req_start,
  input  logic [N_REQ*WIDTH-1:0]    req_base,
  input  logic [N_REQ*WIDTH-1:0]    req_limit,
  input  logic [N_REQ*WIDTH-1:0]    req_step,
  input  logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          req_grant,
  output logic [N_REQ-1:0]          out_valid,
  output logic signed [WIDTH-1:0]   out_0,
  output logic signed [WIDTH-1:0]   out_1,
  output logic [N_REQ-1:0]          out_done,
  output logic                      busy,
  output logic [OWW-1:0]            owner,
  output logic [15:0]               jobs_done,
  output logic                      gen_start,
  output logic signed [WIDTH-1:0]   gen_base,
  output logic signed [WIDTH-1:0]   gen_limit,
  output logic signed [WIDTH-1:0]   gen_step,
  output logic                      gen_ready,
  input  logic                      gen_valid,
  input  logic                      gen_done,
  input  logic signed [WIDTH-1:0]   gen_0,
  input  logic signed [WIDTH-1:0]   gen_1
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE} state_t;

  state_t         state;
  logic [OWW-1:0] ptr;
  logic           any_req;
  logic [OWW-1:0] winner;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [OWW-1:0] next_idx(input logic [OWW-1:0] idx);
    int n;
    n = (int'(idx) + 1) % N_REQ;
    return OWW'(n);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [OWW-1:0] idx);
    logic [N_REQ-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // Round-robin search: first asserted request at or above ptr, wrapping.
  always_comb begin
    int idx;
    any_req = 1'b0;
    winner  = ptr;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!any_req && req_start[idx]) begin
        any_req = 1'b1;
        winner  = OWW'(idx);
      end
    end
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      owner     <= '0;
      jobs_done <= '0;
      gen_base  <= '0;
      gen_limit <= '0;
      gen_step  <= '0;
      gen_start <= 1'b0;
      req_grant <= '0;
      out_done  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner     <= winner;
            gen_base  <= $signed(req_base[int'(winner)*WIDTH +: WIDTH]);
            gen_limit <= $signed(req_limit[int'(winner)*WIDTH +: WIDTH]);
            gen_step  <= $signed(req_step[int'(winner)*WIDTH +: WIDTH]);
            gen_start <= 1'b1;
            req_grant <= onehot(winner);
            busy      <= 1'b1;
            state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          // gen_done is deliberately not looked at here; only RUN completes.
          gen_start <= 1'b0;
          req_grant <= '0;
          state     <= S_RUN;
        end
        S_RUN: begin
          if (gen_done && gen_ready) begin
            out_done <= onehot(owner);
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          out_done  <= '0;
          jobs_done <= sat_inc16(jobs_done);
          ptr       <= next_idx(owner);
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stream steering is purely combinational so the scheduler adds no latency
  // or buffering between generator and consumer.
  always_comb begin
    gen_ready = 1'b0;
    out_valid = '0;
    out_0     = '0;
    out_1     = '0;
    if (state == S_LAUNCH || state == S_RUN)
      gen_ready = req_ready[owner];
    if (state == S_RUN) begin
      out_valid[owner] = gen_valid;
      out_0            = gen_0;
      out_1            = gen_1;
    end
  end

endmodule

// File: tb/tb_hrange_sched.sv
// Directed bench for hrange_sched with a behavioural hrange generator model.
module tb_hrange_sched;
  localparam int N = 4;
  localparam int W = 32;

  logic clk;
  logic rst_n;
  logic [N-1:0]   req_start;
  logic [N*W-1:0] req_base, req_limit, req_step;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_grant, out_valid, out_done;
  logic signed [W-1:0] out_0, out_1;
  logic           busy;
  logic [1:0]     owner;
  logic [15:0]    jobs_done;
  logic           gen_start, gen_ready, gen_valid, gen_done;
  logic signed [W-1:0] gen_base, gen_limit, gen_step, gen_0, gen_1;

  hrange_sched #(.N_REQ(N), .WIDTH(W)) dut (
    ._clock(clk), ._reset_n(rst_n),
    .req_start(req_start), .req_base(req_base), .req_limit(req_limit),
    .req_step(req_step), .req_ready(req_ready),
    .req_grant(req_grant), .out_valid(out_valid), .out_0(out_0), .out_1(out_1),
    .out_done(out_done), .busy(busy), .owner(owner), .jobs_done(jobs_done),
    .gen_start(gen_start), .gen_base(gen_base), .gen_limit(gen_limit),
    .gen_step(gen_step), .gen_ready(gen_ready),
    .gen_valid(gen_valid), .gen_done(gen_done), .gen_0(gen_0), .gen_1(gen_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator model: emits base, base+step, ... below limit; done on last beat.
  logic signed [W-1:0] m_cur, m_lim, m_stp, m_cnt;
  logic m_act;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0; m_cur <= '0; m_lim <= '0; m_stp <= '0; m_cnt <= '0;
    end else if (gen_start) begin
      m_act <= 1'b1; m_cur <= gen_base; m_lim <= gen_limit; m_stp <= gen_step; m_cnt <= '0;
    end else if (m_act && gen_ready) begin
      if (m_cur + m_stp >= m_lim) m_act <= 1'b0;
      else begin m_cur <= m_cur + m_stp; m_cnt <= m_cnt + 1; end
    end
  end
  assign gen_valid = m_act;
  assign gen_done  = m_act && (m_cur + m_stp >= m_lim);
  assign gen_0     = m_cur;
  assign gen_1     = m_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int grants[$];
  int beats[$];
  int b1[$];
  int gaps[$];
  int dones[N];
  int gs_count, multi_err, onehot_err, mirror_err, mux_err, dready_err;
  int last_done_cyc;
  logic signed [W-1:0] cap_base, cap_lim, cap_stp;
  logic cont;
  logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic set_args(input int i, input int b, input int l, input int s);
    req_base[i*W +: W]  = b;
    req_limit[i*W +: W] = l;
    req_step[i*W +: W]  = s;
  endtask

  task automatic clear_rec();
    grants.delete(); beats.delete(); b1.delete(); gaps.delete();
    foreach (dones[i]) dones[i] = 0;
    gs_count = 0; multi_err = 0; onehot_err = 0; mirror_err = 0;
    mux_err = 0; dready_err = 0; last_done_cyc = -1;
  endtask

  task automatic record();
    if (req_grant != '0) begin
      for (int i = 0; i < N; i++) if (req_grant[i]) grants.push_back(i);
      if ($countones(req_grant) != 1 || !gen_start) onehot_err++;
    end
    if (gen_start) begin
      gs_count++;
      cap_base = gen_base; cap_lim = gen_limit; cap_stp = gen_step;
      // Edges from the completion edge to the launch edge.
      if (last_done_cyc >= 0) begin
        gaps.push_back(cyc - last_done_cyc - 1);
        last_done_cyc = -1;
      end
    end
    if ($countones(out_valid) > 1) multi_err++;
    for (int i = 0; i < N; i++) begin
      if (out_valid[i] && req_ready[i]) begin
        beats.push_back(i*1000 + int'(out_0));
        b1.push_back(int'(out_1));
      end
      if (out_done[i]) dones[i]++;
    end
    if (busy && out_done == '0 && gen_ready !== req_ready[owner]) mirror_err++;
    if (out_done != '0 && gen_ready) dready_err++;
    if (!busy && (out_0 != 0 || out_1 != 0 || gen_ready || out_valid != '0)) mux_err++;
    if (gen_done && gen_ready) last_done_cyc = cyc;
  endtask

  // Called at a negedge after inputs are driven; samples just before the posedge.
  task automatic tick();
    #1;
    record();
    if (!cont)
      for (int i = 0; i < N; i++) if (req_grant[i]) req_start[i] = 1'b0;
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_jobs(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (int'(jobs_done) < n && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_jobs_done"}, jobs_done, n);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; req_start = '0; req_ready = '1; cont = 1'b0;
    req_base = '0; req_limit = '0; req_step = '0;
    clear_rec();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    // Reset state
    rst_n = 1'b0; req_start = '0; req_ready = '1; cont = 1'b0;
    req_base = '0; req_limit = '0; req_step = '0;
    clear_rec();
    @(negedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {gen_start, req_grant, out_valid, out_done, gen_ready}, 0);
    chk("rst_jobs_owner", {jobs_done, owner}, 0);
    chk("rst_args", {gen_base, gen_limit, gen_step}, 0);
    reset_dut();

    // Single job
    set_args(0, 0, 10, 2);
    req_start[0] = 1'b1;
    wait_jobs(1, 100, "single");
    chk("single_ngrant", grants.size(), 1);
    chk("single_grant", grants.size() > 0 ? grants[0] : -1, 0);
    chk("single_gen_start", gs_count, 1);
    chk("single_base", cap_base, 0);
    chk("single_limit", cap_lim, 10);
    chk("single_step", cap_stp, 2);
    chk("single_nbeats", beats.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("single_out0_%0d", i), i < beats.size() ? beats[i] : -1, 2*i);
      chk($sformatf("single_out1_%0d", i), i < b1.size() ? b1[i] : -1, i);
    end
    chk("single_done", dones[0], 1);
    chk("single_mux", mux_err, 0);

    // Contention: all four at once
    reset_dut();
    for (int i = 0; i < N; i++) set_args(i, 0, 10, 2);
    req_start = 4'hF;
    wait_jobs(4, 400, "contend");
    chk("contend_ngrant", grants.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("contend_grant_%0d", i), i < grants.size() ? grants[i] : -1, i);
    chk("contend_nbeats", beats.size(), 20);
    for (int i = 0; i < 20; i++)
      chk($sformatf("contend_beat_%0d", i), i < beats.size() ? beats[i] : -1,
          (i / 5) * 1000 + 2 * (i % 5));
    for (int i = 0; i < N; i++) chk($sformatf("contend_done_%0d", i), dones[i], 1);
    chk("contend_onehot_valid", multi_err, 0);
    chk("contend_onehot_grant", onehot_err, 0);
    chk("contend_ngaps", gaps.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("gap_%0d", i), i < gaps.size() ? gaps[i] : -1, 2);

    // Fairness: 1 and 3 request continuously
    reset_dut();
    set_args(1, 0, 2, 1);
    set_args(3, 5, 7, 1);
    cont = 1'b1;
    req_start = 4'b1010;
    wait_jobs(4, 300, "fair");
    req_start = '0;
    cont = 1'b0;
    tick(); tick(); tick();
    chk("fair_ngrant", grants.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("fair_grant_%0d", i), i < grants.size() ? grants[i] : -1, (i % 2 == 0) ? 1 : 3);
    chk("fair_owner", owner, 3);
    chk("fair_beat3", beats.size() > 3 ? beats[3] : -1, 3006);

    // Backpressure on requester 2
    clear_rec();
    set_args(2, 0, 10, 2);
    req_start[2] = 1'b1;
    k = 0;
    while (jobs_done < 16'd5 && k < 200) begin
      req_ready[2] = pat[k % 4];
      tick();
      k++;
    end
    req_ready = '1;
    chk("bp_jobs_done", jobs_done, 5);
    chk("bp_nbeats", beats.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("bp_beat_%0d", i), i < beats.size() ? beats[i] : -1, 2000 + 2*i);
    chk("bp_ready_mirror", mirror_err, 0);
    chk("bp_ready_done", dready_err, 0);
    chk("bp_done", dones[2], 1);

    // Mid-job reset after the second beat
    clear_rec();
    set_args(0, 0, 10, 2);
    req_start[0] = 1'b1;
    k = 0;
    while (beats.size() < 2 && k < 50) begin
      tick();
      k++;
    end
    chk("mr_two_beats", beats.size(), 2);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_pulses", {gen_start, req_grant, out_valid, out_done, gen_ready}, 0);
    chk("mr_data", {out_0, out_1}, 0);
    chk("mr_jobs_owner", {jobs_done, owner}, 0);
    chk("mr_args", {gen_base, gen_limit, gen_step}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req_start = '0;
    repeat (4) tick();
    chk("mr_no_done", dones[0] + dones[1] + dones[2] + dones[3], 0);
    set_args(3, 0, 4, 2);
    req_start = 4'b1001;
    k = 0;
    while (grants.size() == 0 && k < 20) begin
      tick();
      k++;
    end
    chk("mr_first_grant", grants.size() > 0 ? grants[0] : -1, 0);
    wait_jobs(2, 200, "mr");
    chk("mr_done0", dones[0], 1);
    chk("mr_done3", dones[3], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hrange_sched.md
# hrange_sched

Round-robin scheduler that shares one `hrange`-style generator instance among `N_REQ` requesters. Each requester posts a (base, limit, step) job. The block grants one job at a time, pulses the generator's start with the latched arguments, and steers the generator's valid/ready output stream to the owning requester. It releases the generator after done. It sits between the requester clients and a single generator, and owns that generator's start/ready handshake.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 32, signed argument/output width
- `OWW`, $clog2(N_REQ), owner index width (derived)

- `_clock`  in  1  rising-edge clock
- `_reset_n`  in  1  asynchronous, active-low reset; also drives the generator's reset
- `req_start`  in  N_REQ  level request per requester; held until its grant pulse
- `req_base`, `req_limit`, `req_step`  in  N_REQ*WIDTH  packed per-requester arguments; slice i is valid while `req_start[i]` is high
- `req_ready`  in  N_REQ  per-requester consumer ready
- `req_grant`  out  N_REQ  one-hot, one-cycle pulse when a job is launched
- `out_valid`  out  N_REQ  per-requester valid, only for the owner
- `out_0`, `out_1`  out  WIDTH each  shared data, meaningful where `out_valid[i]` is high
- `out_done`  out  N_REQ  one-cycle completion pulse to the owner
- `busy`  out  1  high when not IDLE
- `owner`  out  OWW  current or last owner index
- `jobs_done`  out  16  completed-job counter, saturates at 16'hFFFF
- `gen_start`  out  1  generator start
- `gen_base`, `gen_limit`, `gen_step`  out  WIDTH each  latched arguments
- `gen_ready`  out  1  generator ready
- `gen_valid`, `gen_done`  in  1 each  generator status
- `gen_0`, `gen_1`  in  WIDTH each  generator outputs

## Operation
- **States:** IDLE, LAUNCH, RUN, DONE. Encoding is free.
- **IDLE:**
  - If any `req_start` is high at a rising edge, choose the winner. The search starts at `ptr` and wraps upward; `ptr` resets to 0.
  - At that edge: latch `owner` and the winner's argument slices into `gen_base/limit/step`, then go to LAUNCH.
- **LAUNCH (1 cycle):**
  - `gen_start`=1 and `req_grant[owner]`=1.
  - `gen_ready`=`req_ready[owner]`.
  - Then go to RUN.
- **RUN:**
  - `gen_ready`=`req_ready[owner]`.
  - `out_valid[owner]`=`gen_valid`; all other bits of `out_valid` are 0.
  - `out_0`/`out_1`=`gen_0`/`gen_1`, passed through combinationally.
  - Exit to DONE at the edge where `gen_done && gen_ready`. A final valid beat presented in that same cycle is delivered.
- **DONE (1 cycle):**
  - `out_done[owner]`=1 and `gen_ready`=0.
  - At the exit edge: `jobs_done` increments (saturating) and `ptr` becomes (`owner`+1) mod `N_REQ`. Then go to IDLE.
- **Signals outside their states:**
  - `gen_start`, `req_grant`, `out_valid` and `out_done` are 0 outside the states listed above.
  - `gen_ready`=0 in IDLE.
- **Request handling:**
  - Requests arriving outside IDLE are ignored until the next IDLE. No queueing beyond the `req_start` levels.
  - The arguments are held stable on `gen_*` from LAUNCH through DONE.
- **Output muxing:** `out_0`/`out_1` are muxed to the generator whenever state is RUN, else 0.

## Timing
- **Reset:** `_reset_n` low immediately forces the following, asynchronously:
  - state=IDLE
  - `ptr`=0, `owner`=0, `jobs_done`=0
  - `gen_base/limit/step`=0
  - all pulse and valid outputs and `gen_ready`=0
- **Reset mid-job:** the job is abandoned and no `out_done` is issued. The generator is reset by the same signal.
- **Grant latency:** `req_start` sampled high in IDLE at edge k means LAUNCH (`gen_start`, `req_grant`) during cycle k..k+1 and RUN from edge k+1.
- **Job-to-job gap:** the completion edge, then DONE, then IDLE, then the grant edge. The minimum gap from the last generator transfer to the next `gen_start` is 2 cycles.
- **Backpressure:** `req_ready[owner]` low stalls the generator. The scheduler adds no buffering and no extra latency to data.
- **Simultaneous requests:** exactly one grant, chosen by the round-robin order.
- **`req_start` deassertion:** `req_start` deasserted before the grant edge withdraws the request without side effects.
- **`gen_done` in LAUNCH:** ignored; completion is only recognised in RUN.

## Test plan
- **Single job:** requester 0 issues (0,10,2) with `req_ready` held at 1.
  - `req_grant`=4'b0001 for 1 cycle; `gen_start` pulses once with `gen_base`=0, `gen_limit`=10, `gen_step`=2.
  - `out_valid[0]` beats carry `out_0` = 0,2,4,6,8; then one `out_done[0]` pulse; `jobs_done`=1.
- **Contention:** all 4 requesters assert in the same cycle, each with (0,10,2).
  - Grants follow the order 0,1,2,3; each receives exactly 5 beats and one `out_done`.
  - `out_valid` never has more than one bit set; `jobs_done`=4.
- **Fairness:** requesters 1 and 3 request continuously.
  - Grants alternate 1,3,1,3; `ptr` wrap is verified.
- **Backpressure:** `req_ready[2]` is toggled 1,0,0,1 during requester 2's (0,10,2) job.
  - The `out_0` sequence is unchanged at 0,2,4,6,8 with no duplicates or drops.
  - `gen_ready` mirrors `req_ready[2]`.
- **Mid-job reset:** `_reset_n` is pulled low during RUN after the 2nd beat.
  - All outputs go to 0 immediately; no `out_done`; `jobs_done`=0.
  - After release, a new request from requester 0 is granted first.
- **Timing:** the gap from the final `gen_done`&&`gen_ready` edge to the next `gen_start` is exactly 2 cycles when the next request is already pending.
